// File: rtl/vga_src_switch.sv
// VGA stream selector: muxes N_SRC registered VGA streams onto one output, switching on
// edge-detected key codes either immediately or at the active source's next frame boundary.
module vga_src_switch #(
    parameter int unsigned     N_SRC       = 3,
    parameter int unsigned     HOME_SRC    = 0,
    parameter int unsigned     KEY_W       = 4,
    parameter logic [KEY_W-1:0] KEY_ESC    = 4'hF,
    parameter logic [KEY_W-1:0] KEY_IDLE   = 4'h0,
    parameter bit              SYNC_SWITCH = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [KEY_W-1:0]           key_i,
    input  logic                       sel_enable_i,
    input  logic [N_SRC*11-1:0]        src_vcount_i,
    input  logic [N_SRC*11-1:0]        src_hcount_i,
    input  logic [N_SRC-1:0]           src_vsync_i,
    input  logic [N_SRC-1:0]           src_hsync_i,
    input  logic [N_SRC-1:0]           src_vblnk_i,
    input  logic [N_SRC-1:0]           src_hblnk_i,
    input  logic [N_SRC*12-1:0]        src_rgb_i,
    output logic [10:0]                out_vcount_o,
    output logic [10:0]                out_hcount_o,
    output logic                       out_vsync_o,
    output logic                       out_hsync_o,
    output logic                       out_vblnk_o,
    output logic                       out_hblnk_o,
    output logic [11:0]                out_rgb_o,
    output logic [N_SRC*KEY_W-1:0]     key_route_o,
    output logic [$clog2(N_SRC)-1:0]   active_src_o,
    output logic                       switch_pending_o,
    output logic                       switched_o
);

    localparam int unsigned SW = $clog2(N_SRC);

    typedef enum logic {StIdle, StPending} state_e;

    state_e             state_q, state_d;
    logic [SW-1:0]      cur_q, cur_d, pend_q, pend_d;
    logic [KEY_W-1:0]   key_q;
    logic [N_SRC-1:0]   vblnk_q;

    logic               key_evt, sel_req, ret_req, cancel_req, boundary;
    logic [SW-1:0]      target;

    logic [10:0]            vcount_d, hcount_d;
    logic                   vsync_d, hsync_d, vblnk_d, hblnk_d;
    logic [11:0]            rgb_d;
    logic [N_SRC*KEY_W-1:0] route_d;
    int                     sel;

    always_comb begin
        key_evt    = (key_i != key_q) && (key_i != KEY_IDLE);
        sel_req    = key_evt && (cur_q == SW'(HOME_SRC)) && sel_enable_i
                     && (key_i >= KEY_W'(1)) && (key_i <= KEY_W'(N_SRC - 1))
                     && (key_i != KEY_W'(HOME_SRC));
        ret_req    = key_evt && (key_i == KEY_ESC) && (cur_q != SW'(HOME_SRC));
        cancel_req = key_evt && (key_i == KEY_ESC) && (state_q == StPending)
                     && (cur_q == SW'(HOME_SRC));
        target     = ret_req ? SW'(HOME_SRC) : SW'(key_i);
        boundary   = src_vblnk_i[cur_q] && !vblnk_q[cur_q];
    end

    always_comb begin
        cur_d   = cur_q;
        pend_d  = pend_q;
        state_d = state_q;
        if (SYNC_SWITCH) begin
            // Commit uses the pend held before this cycle; a same-cycle request queues behind it.
            if (boundary && state_q == StPending) begin
                cur_d   = pend_q;
                state_d = StIdle;
            end
            if (sel_req || ret_req) begin
                pend_d  = target;
                state_d = StPending;
            end else if (cancel_req) begin
                state_d = StIdle;
            end
        end else if (sel_req || ret_req) begin
            cur_d = target;
        end
    end

    always_comb begin
        sel      = int'(cur_d);
        vcount_d = src_vcount_i[sel*11 +: 11];
        hcount_d = src_hcount_i[sel*11 +: 11];
        vsync_d  = src_vsync_i[sel];
        hsync_d  = src_hsync_i[sel];
        vblnk_d  = src_vblnk_i[sel];
        hblnk_d  = src_hblnk_i[sel];
        rgb_d    = src_rgb_i[sel*12 +: 12];
        route_d  = '0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            route_d[i*KEY_W +: KEY_W] = (SW'(i) == cur_d) ? key_i : KEY_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cur_q        <= SW'(HOME_SRC);
            pend_q       <= SW'(HOME_SRC);
            key_q        <= KEY_IDLE;
            vblnk_q      <= '0;
            out_vcount_o <= '0;
            out_hcount_o <= '0;
            out_vsync_o  <= 1'b0;
            out_hsync_o  <= 1'b0;
            out_vblnk_o  <= 1'b0;
            out_hblnk_o  <= 1'b0;
            out_rgb_o    <= '0;
            key_route_o  <= {N_SRC{KEY_IDLE}};
            switched_o   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            pend_q       <= pend_d;
            key_q        <= key_i;
            vblnk_q      <= src_vblnk_i;
            out_vcount_o <= vcount_d;
            out_hcount_o <= hcount_d;
            out_vsync_o  <= vsync_d;
            out_hsync_o  <= hsync_d;
            out_vblnk_o  <= vblnk_d;
            out_hblnk_o  <= hblnk_d;
            out_rgb_o    <= rgb_d;
            key_route_o  <= route_d;
            switched_o   <= (cur_d != cur_q);
        end
    end

    assign active_src_o     = cur_q;
    assign switch_pending_o = (state_q == StPending);

endmodule

// File: tb/tb_vga_src_switch.sv
// Directed bench: one immediate-mode and one frame-synchronised instance share the source
// streams but have independent key inputs.
module tb_vga_src_switch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  key_a, key_b;
    logic        sel_en;
    logic [32:0] vc, hc;
    logic [2:0]  vs, hs, vb, hb;
    logic [35:0] rgb;

    logic [10:0] a_vc, a_hc, b_vc, b_hc;
    logic        a_vs, a_hs, a_vb, a_hb, b_vs, b_hs, b_vb, b_hb;
    logic [11:0] a_rgb, b_rgb, a_route, b_route;
    logic [1:0]  a_act, b_act;
    logic        a_pend, b_pend, a_sw, b_sw;

    int cnt, pass_cnt, total_cnt, sw_count;

    vga_src_switch #(.N_SRC(3), .HOME_SRC(0), .KEY_W(4), .KEY_ESC(4'hF), .KEY_IDLE(4'h0),
                     .SYNC_SWITCH(1'b0)) u_imm (
        .clk(clk), .rst(rst), .key_i(key_a), .sel_enable_i(sel_en),
        .src_vcount_i(vc), .src_hcount_i(hc), .src_vsync_i(vs), .src_hsync_i(hs),
        .src_vblnk_i(vb), .src_hblnk_i(hb), .src_rgb_i(rgb),
        .out_vcount_o(a_vc), .out_hcount_o(a_hc), .out_vsync_o(a_vs), .out_hsync_o(a_hs),
        .out_vblnk_o(a_vb), .out_hblnk_o(a_hb), .out_rgb_o(a_rgb), .key_route_o(a_route),
        .active_src_o(a_act), .switch_pending_o(a_pend), .switched_o(a_sw)
    );

    vga_src_switch #(.N_SRC(3), .HOME_SRC(0), .KEY_W(4), .KEY_ESC(4'hF), .KEY_IDLE(4'h0),
                     .SYNC_SWITCH(1'b1)) u_syn (
        .clk(clk), .rst(rst), .key_i(key_b), .sel_enable_i(sel_en),
        .src_vcount_i(vc), .src_hcount_i(hc), .src_vsync_i(vs), .src_hsync_i(hs),
        .src_vblnk_i(vb), .src_hblnk_i(hb), .src_rgb_i(rgb),
        .out_vcount_o(b_vc), .out_hcount_o(b_hc), .out_vsync_o(b_vs), .out_hsync_o(b_hs),
        .out_vblnk_o(b_vb), .out_hblnk_o(b_hb), .out_rgb_o(b_rgb), .key_route_o(b_route),
        .active_src_o(b_act), .switch_pending_o(b_pend), .switched_o(b_sw)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] exp_rgb(int i);
        return 12'(273 * (i + 1));
    endfunction
    function automatic logic [10:0] exp_hc(int i, int c);
        return 11'((c * 4 + i) % 2048);
    endfunction
    function automatic logic [10:0] exp_vc(int i, int c);
        return 11'(i * 100 + c / 8);
    endfunction
    function automatic logic exp_hs(int i, int c);
        return 1'(((c >> 1) ^ i) & 1);
    endfunction
    function automatic logic exp_vs(int i);
        return (i == 1);
    endfunction
    function automatic logic exp_hb(int i, int c);
        return 1'(((c >> 2) + i) & 1);
    endfunction

    task automatic drive();
        for (int i = 0; i < 3; i++) begin
            hc[i*11 +: 11] = exp_hc(i, cnt);
            vc[i*11 +: 11] = exp_vc(i, cnt);
            rgb[i*12 +: 12] = exp_rgb(i);
            hs[i] = exp_hs(i, cnt);
            vs[i] = exp_vs(i);
            hb[i] = exp_hb(i, cnt);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cnt++;
        drive();
    endtask

    task automatic test_reset();
        logic [37:0] exp_fields;
        key_a = 4'h0; key_b = 4'h0; sel_en = 1'b1; vb = 3'b000; cnt = 0;
        drive();
        #3 rst = 1'b1;
        #1;
        total_cnt++;
        if ({a_vc, a_hc, a_vs, a_hs, a_vb, a_hb, a_rgb} !== 38'h0)
            $display("FAIL reset_out_a: got %0h expected 0", {a_vc, a_hc, a_vs, a_hs, a_vb, a_hb, a_rgb});
        else pass_cnt++;
        total_cnt++;
        if ({b_vc, b_hc, b_vs, b_hs, b_vb, b_hb, b_rgb} !== 38'h0)
            $display("FAIL reset_out_b: got %0h expected 0", {b_vc, b_hc, b_vs, b_hs, b_vb, b_hb, b_rgb});
        else pass_cnt++;
        total_cnt++;
        if ({a_route, b_route} !== 24'h0)
            $display("FAIL reset_route: got %0h expected 0", {a_route, b_route});
        else pass_cnt++;
        total_cnt++;
        if ({a_act, b_act, a_pend, b_pend, a_sw, b_sw} !== 8'h0)
            $display("FAIL reset_ctrl: got %0h expected 0", {a_act, b_act, a_pend, b_pend, a_sw, b_sw});
        else pass_cnt++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            exp_fields = {exp_vc(0, cnt - 1), exp_hc(0, cnt - 1), exp_vs(0), exp_hs(0, cnt - 1),
                          1'b0, exp_hb(0, cnt - 1), exp_rgb(0)};
            total_cnt++;
            if ({a_vc, a_hc, a_vs, a_hs, a_vb, a_hb, a_rgb} !== exp_fields)
                $display("FAIL idle_mirror_src0: got %0h expected %0h",
                         {a_vc, a_hc, a_vs, a_hs, a_vb, a_hb, a_rgb}, exp_fields);
            else pass_cnt++;
        end
        total_cnt++;
        if ({a_act, a_route, b_pend} !== 15'h0)
            $display("FAIL idle_ctrl: got %0h expected 0", {a_act, a_route, b_pend});
        else pass_cnt++;
    endtask

    task automatic test_imm_switch();
        key_a = 4'h1;
        step();
        total_cnt++;
        if ({a_act, a_sw} !== {2'd1, 1'b1})
            $display("FAIL imm_select: act/sw got %0h expected %0h", {a_act, a_sw}, {2'd1, 1'b1});
        else pass_cnt++;
        total_cnt++;
        if ({a_rgb, a_hc} !== {exp_rgb(1), exp_hc(1, cnt - 1)})
            $display("FAIL imm_select_out: got %0h expected %0h", {a_rgb, a_hc},
                     {exp_rgb(1), exp_hc(1, cnt - 1)});
        else pass_cnt++;
        sw_count = 0;
        repeat (100) begin
            step();
            if (a_sw) sw_count++;
        end
        total_cnt++;
        if (sw_count !== 0 || a_act !== 2'd1)
            $display("FAIL imm_hold_no_retrigger: pulses %0d act %0d expected 0 and 1", sw_count, a_act);
        else pass_cnt++;
        total_cnt++;
        if (a_route !== 12'h010)
            $display("FAIL imm_route_held: got %0h expected 010", a_route);
        else pass_cnt++;
        key_a = 4'hF;
        step();
        total_cnt++;
        if ({a_act, a_sw, a_rgb} !== {2'd0, 1'b1, exp_rgb(0)})
            $display("FAIL imm_return: got %0h expected %0h", {a_act, a_sw, a_rgb}, {2'd0, 1'b1, exp_rgb(0)});
        else pass_cnt++;
        total_cnt++;
        if (a_route !== 12'h00F)
            $display("FAIL imm_return_route: got %0h expected 00f", a_route);
        else pass_cnt++;
        key_a = 4'h0;
        step();
    endtask

    task automatic test_ignored();
        sel_en = 1'b0; key_a = 4'h1;
        step();
        total_cnt++;
        if ({a_act, a_sw} !== 3'b000)
            $display("FAIL ign_sel_disabled: got %0h expected 0", {a_act, a_sw});
        else pass_cnt++;
        key_a = 4'h0; sel_en = 1'b1;
        step();
        key_a = 4'h7;
        step();
        total_cnt++;
        if ({a_act, a_sw, a_route} !== {3'b000, 12'h007})
            $display("FAIL ign_out_of_range: got %0h expected 7", {a_act, a_sw, a_route});
        else pass_cnt++;
        key_a = 4'h0;
        step();
        key_a = 4'hF;
        step();
        total_cnt++;
        if ({a_act, a_sw} !== 3'b000)
            $display("FAIL ign_esc_at_home: got %0h expected 0", {a_act, a_sw});
        else pass_cnt++;
        key_a = 4'h0;
        step();
        key_a = 4'h1;
        step();
        key_a = 4'h0;
        step();
        key_a = 4'h1;
        step();
        total_cnt++;
        if ({a_act, a_sw} !== {2'd1, 1'b0})
            $display("FAIL ign_same_src: got %0h expected %0h", {a_act, a_sw}, {2'd1, 1'b0});
        else pass_cnt++;
        key_a = 4'hF;
        step();
        key_a = 4'h0;
        step();
        total_cnt++;
        if (a_act !== 2'd0)
            $display("FAIL ign_back_home: got %0d expected 0", a_act);
        else pass_cnt++;
    endtask

    task automatic test_sync_switch();
        key_b = 4'h2;
        step();
        total_cnt++;
        if ({b_pend, b_act, b_rgb} !== {1'b1, 2'd0, exp_rgb(0)})
            $display("FAIL sync_pending: got %0h expected %0h", {b_pend, b_act, b_rgb}, {1'b1, 2'd0, exp_rgb(0)});
        else pass_cnt++;
        repeat (5) step();
        total_cnt++;
        if ({b_pend, b_act, b_rgb} !== {1'b1, 2'd0, exp_rgb(0)})
            $display("FAIL sync_hold: got %0h expected %0h", {b_pend, b_act, b_rgb}, {1'b1, 2'd0, exp_rgb(0)});
        else pass_cnt++;
        vb = 3'b101;
        step();
        total_cnt++;
        if ({b_act, b_sw, b_pend, b_rgb, b_vb} !== {2'd2, 1'b1, 1'b0, exp_rgb(2), 1'b1})
            $display("FAIL sync_commit: got %0h expected %0h", {b_act, b_sw, b_pend, b_rgb, b_vb},
                     {2'd2, 1'b1, 1'b0, exp_rgb(2), 1'b1});
        else pass_cnt++;
        step();
        total_cnt++;
        if ({b_act, b_sw} !== {2'd2, 1'b0})
            $display("FAIL sync_single_pulse: got %0h expected %0h", {b_act, b_sw}, {2'd2, 1'b0});
        else pass_cnt++;
        key_b = 4'hF;
        step();
        total_cnt++;
        if ({b_pend, b_act} !== {1'b1, 2'd2})
            $display("FAIL sync_return_pending: got %0h expected %0h", {b_pend, b_act}, {1'b1, 2'd2});
        else pass_cnt++;
        vb = 3'b001;
        step();
        vb = 3'b101;
        step();
        total_cnt++;
        if ({b_act, b_sw, b_pend} !== {2'd0, 1'b1, 1'b0})
            $display("FAIL sync_return_commit: got %0h expected %0h", {b_act, b_sw, b_pend}, {2'd0, 1'b1, 1'b0});
        else pass_cnt++;
        vb = 3'b000; key_b = 4'h0;
        step();
    endtask

    task automatic test_overwrite();
        key_b = 4'h1;
        step();
        key_b = 4'h2;
        step();
        vb = 3'b001;
        step();
        total_cnt++;
        if ({b_act, b_pend} !== {2'd2, 1'b0})
            $display("FAIL overwrite_commit: got %0h expected %0h", {b_act, b_pend}, {2'd2, 1'b0});
        else pass_cnt++;
        vb = 3'b000; key_b = 4'hF;
        step();
        vb = 3'b100;
        step();
        total_cnt++;
        if (b_act !== 2'd0)
            $display("FAIL overwrite_return: got %0d expected 0", b_act);
        else pass_cnt++;
        vb = 3'b000; key_b = 4'h0;
        step();
    endtask

    task automatic test_cancel();
        key_b = 4'h1;
        step();
        key_b = 4'hF;
        step();
        total_cnt++;
        if (b_pend !== 1'b0)
            $display("FAIL cancel_clears: got %0d expected 0", b_pend);
        else pass_cnt++;
        vb = 3'b001;
        step();
        total_cnt++;
        if ({b_act, b_sw} !== 3'b000)
            $display("FAIL cancel_no_switch: got %0h expected 0", {b_act, b_sw});
        else pass_cnt++;
        vb = 3'b000; key_b = 4'h0;
        step();
    endtask

    task automatic test_reset_pending();
        key_b = 4'h2;
        step();
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if ({b_pend, b_act} !== 3'b000)
            $display("FAIL rst_pending_async: got %0h expected 0", {b_pend, b_act});
        else pass_cnt++;
        key_b = 4'h0; key_a = 4'h0;
        @(negedge clk);
        rst = 1'b0;
        step();
        vb = 3'b001;
        step();
        total_cnt++;
        if ({b_act, b_sw, b_pend} !== 4'h0)
            $display("FAIL rst_pending_no_switch: got %0h expected 0", {b_act, b_sw, b_pend});
        else pass_cnt++;
        vb = 3'b000;
        step();
    endtask

    task automatic test_back_to_back();
        key_b = 4'h1;
        step();
        key_b = 4'h2; vb = 3'b001;
        step();
        total_cnt++;
        if ({b_act, b_pend} !== {2'd1, 1'b1})
            $display("FAIL b2b_commit_old: got %0h expected %0h", {b_act, b_pend}, {2'd1, 1'b1});
        else pass_cnt++;
        vb = 3'b000;
        step();
        vb = 3'b010;
        step();
        total_cnt++;
        if ({b_act, b_pend} !== {2'd2, 1'b0})
            $display("FAIL b2b_commit_new: got %0h expected %0h", {b_act, b_pend}, {2'd2, 1'b0});
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        test_reset();
        test_imm_switch();
        test_ignored();
        test_sync_switch();
        test_overwrite();
        test_cancel();
        test_reset_pending();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
